// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory wait freeze,
// with a saturating stall counter and a sticky data-memory timeout flag.
//
// state      | meaning
// RUN        | no hazard on the previous cycle
// LOAD_STALL | previous cycle inserted a load-use bubble
// MEM_WAIT   | previous cycle froze the pipe waiting on data memory
// FLUSH      | previous cycle squashed the wrong-path fetch after a taken branch
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_RegisterRs,
  input  logic [4:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_UsesRt,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRt,
  input  logic        EX_BranchTaken,
  input  logic        EX_MEM_MemAccess,
  input  logic        DMem_Ready,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic        Pipe_Freeze,
  output logic [1:0]  HazardState,
  output logic [15:0] StallCount,
  output logic        MemTimeout
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10,
    FLUSH      = 2'b11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_stall_cnt;
  logic [7:0]  r_wait_cnt;
  logic        r_timeout;
  logic        w_mem_wait;
  logic        w_load_use;

  assign w_mem_wait = EX_MEM_MemAccess & ~DMem_Ready;
  assign w_load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                      ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                       (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  // Next state depends only on the current conditions, never on r_state,
  // so stall and flush states last one cycle unless the hazard persists.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    Pipe_Freeze  = 1'b0;
    w_next       = RUN;
    if (w_mem_wait) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      Pipe_Freeze = 1'b1;
      w_next      = MEM_WAIT;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
      w_next       = FLUSH;
    end else if (w_load_use) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
      w_next       = LOAD_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (!PCWrite && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Timeout fires on the 256th consecutive wait edge, once the counter is already pinned at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else if (w_mem_wait) begin
      if (r_wait_cnt != 8'hFF) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  assign HazardState = r_state;
  assign StallCount  = r_stall_cnt;
  assign MemTimeout  = r_timeout;

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports in this order: clk, rst_n.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: IF_ID_RegisterRs  input  5  Rs field of the instruction in decode.
REQ-005 Port: IF_ID_RegisterRt  input  5  Rt field of the instruction in decode.
REQ-006 Port: IF_ID_UsesRt  input  1  the decode instruction reads Rt as a source (R-type, beq, sw).
REQ-007 Port: ID_EX_MemRead  input  1  the instruction in EX is a load.
REQ-008 Port: ID_EX_RegisterRt  input  5  load destination in EX.
REQ-009 Port: EX_BranchTaken  input  1  a branch in EX resolved taken this cycle.
REQ-010 Port: EX_MEM_MemAccess  input  1  the MEM stage holds a load or store with a data-memory request pending.
REQ-011 Port: DMem_Ready  input  1  data memory completes the MEM-stage access this cycle.
REQ-012 Port: PCWrite  output  1  PC may update.
REQ-013 Port: IF_ID_Write  output  1  the IF/ID register may load.
REQ-014 Port: IF_ID_Flush  output  1  zero IF/ID (nop).
REQ-015 Port: ID_EX_Bubble  output  1  zero the ID/EX control fields.
REQ-016 Port: Pipe_Freeze  output  1  hold the ID/EX, EX/MEM and MEM/WB registers.
REQ-017 Port: HazardState  output  2  registered FSM state.
REQ-018 Port: StallCount  output  16  saturating count of cycles with PCWrite=0.
REQ-019 Port: MemTimeout  output  1  sticky flag: data-memory wait exceeded its limit.

Function
REQ-020 The FSM states SHALL be encoded RUN=00, LOAD_STALL=01, MEM_WAIT=10 and FLUSH=11, and HazardState SHALL equal the state register.
REQ-021 The control outputs (PCWrite through Pipe_Freeze) SHALL be combinational functions of the current-cycle inputs, giving zero latency, and state SHALL update on the rising clock edge.
REQ-022 Mem-wait condition: EX_MEM_MemAccess=1 and DMem_Ready=0.
REQ-023 Load-use condition: ID_EX_MemRead=1, ID_EX_RegisterRt!=0, and either ID_EX_RegisterRt==IF_ID_RegisterRs or (IF_ID_UsesRt=1 and ID_EX_RegisterRt==IF_ID_RegisterRt).
REQ-024 Conditions SHALL be evaluated with fixed priority: mem-wait, then EX_BranchTaken, then load-use, then none.
REQ-025 Mem-wait: Pipe_Freeze=1, PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0 and ID_EX_Bubble=0; next state MEM_WAIT.
REQ-026 Branch taken, no mem-wait: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1 and Pipe_Freeze=0; next state FLUSH.
REQ-027 Load-use only: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0 and Pipe_Freeze=0; next state LOAD_STALL.
REQ-028 No condition: PCWrite=1, IF_ID_Write=1 and all other controls 0; next state RUN.
REQ-029 From any state, the next state SHALL be chosen by REQ-024 through REQ-028 alone, so LOAD_STALL and FLUSH last exactly one cycle unless a condition re-arises.
REQ-030 A branch taken during a load-use cycle SHALL win, with no load stall.
REQ-031 A branch taken during mem-wait SHALL be ignored until the wait ends, because EX is frozen and EX_BranchTaken persists.
REQ-032 StallCount SHALL increment by 1 on every clock edge where PCWrite=0.
REQ-033 StallCount SHALL saturate at 16'hFFFF and never wrap.
REQ-034 An 8-bit WaitCount SHALL increment on each edge with the mem-wait condition, saturating at 255.
REQ-035 WaitCount SHALL clear on any edge without the mem-wait condition.
REQ-036 MemTimeout SHALL set on the edge where WaitCount==255 and the mem-wait condition holds.
REQ-037 MemTimeout SHALL remain set until reset and SHALL not alter stall behaviour.

Reset
REQ-038 rst_n=0 SHALL immediately and asynchronously force HazardState=RUN, StallCount=0, WaitCount=0 and MemTimeout=0, regardless of clk.
REQ-039 Reset asserted mid-stall or mid-wait SHALL abandon the stall or wait.
REQ-040 After reset, control outputs SHALL follow REQ-028 when inputs are idle.
REQ-041 Release of rst_n SHALL take effect at the next rising clock edge.

Verification
REQ-042 Scenario: ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5 for one cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, next HazardState=01, StallCount=1.
REQ-043 Scenario: load-use with Rt=0, or IF_ID_UsesRt=0 and a match on Rt only -> no stall, PCWrite=1.
REQ-044 Scenario: EX_BranchTaken=1 together with a load-use match -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, HazardState=11 next, StallCount unchanged.
REQ-045 Scenario: EX_MEM_MemAccess=1 with DMem_Ready=0 for 3 cycles then 1 -> Pipe_Freeze=1 for exactly 3 cycles, StallCount=3, HazardState returns to 00.
REQ-046 Scenario: DMem_Ready held 0 for 300 cycles -> MemTimeout=1 from the 256th edge onward and stays 1 after DMem_Ready=1, until rst_n=0.
REQ-047 Scenario: rst_n pulsed low mid-MEM_WAIT with StallCount=40 -> all state cleared without a clock edge.
